// File: rtl/wb_queue.sv
// wb_queue: program-ordered writeback buffer draining one register write per cycle to the bank.
module wb_queue #(
   parameter int DEPTH   = 4,
   parameter bit DROP_R0 = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     mem_valid,
   input  logic [4:0]               mem_rd,
   input  logic [31:0]              mem_data,
   output logic                     mem_ready,
   input  logic                     alu_valid,
   input  logic [4:0]               alu_rd,
   input  logic [31:0]              alu_data,
   output logic                     alu_ready,
   input  logic [4:0]               query_a,
   input  logic [4:0]               query_b,
   output logic                     hazard_a,
   output logic                     hazard_b,
   output logic [4:0]               rf_addr_d,
   output logic [31:0]              rf_data,
   output logic                     rf_write,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [4:0]    rd_q   [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] rel    [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [AW-1:0] head, tail, alu_idx;
   logic [CW-1:0] free;
   logic pop, mem_hs, alu_hs, mem_push, alu_push;
   assign pop       = count != '0;
   assign free      = CW'(DEPTH) - count + CW'(pop);
   assign mem_ready = free != '0;
   assign mem_hs    = mem_valid & mem_ready;
   // dropped r0 writes handshake but never occupy a slot
   assign mem_push  = mem_hs & ~(DROP_R0 && mem_rd == 5'd0);
   assign alu_ready = free > CW'(mem_push);
   assign alu_hs    = alu_valid & alu_ready;
   assign alu_push  = alu_hs & ~(DROP_R0 && alu_rd == 5'd0);
   assign alu_idx   = tail + AW'(mem_push);
   for (genvar s = 0; s < DEPTH; s++) begin : g_vld
      assign rel[s] = AW'(s) - head;
      assign vld[s] = {1'b0, rel[s]} < count;
   end
   always_comb begin
      hazard_a = 1'b0;
      hazard_b = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         hazard_a = hazard_a | (vld[i] & rd_q[i] == query_a);
         hazard_b = hazard_b | (vld[i] & rd_q[i] == query_b);
      end
      hazard_a = hazard_a | (rf_write & rf_addr_d == query_a) | (mem_hs & mem_rd == query_a) | (alu_hs & alu_rd == query_a);
      hazard_b = hazard_b | (rf_write & rf_addr_d == query_b) | (mem_hs & mem_rd == query_b) | (alu_hs & alu_rd == query_b);
      hazard_a = (DROP_R0 && query_a == 5'd0) ? 1'b0 : hazard_a;
      hazard_b = (DROP_R0 && query_b == 5'd0) ? 1'b0 : hazard_b;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         rf_write  <= 1'b0;
         rf_addr_d <= '0;
         rf_data   <= '0;
      end else begin
         head     <= head + AW'(pop);
         tail     <= tail + AW'(mem_push) + AW'(alu_push);
         count    <= count + CW'(mem_push) + CW'(alu_push) - CW'(pop);
         rf_write <= pop;
         if (pop) begin
            rf_addr_d <= rd_q[head];
            rf_data   <= data_q[head];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (mem_push) begin
         rd_q[tail]   <= mem_rd;
         data_q[tail] <= mem_data;
      end
      if (alu_push) begin
         rd_q[alu_idx]   <= alu_rd;
         data_q[alu_idx] <= alu_data;
      end
   end
endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: random and directed stimulus against a queue-based model of the writeback buffer.
module tb_wb_queue;
   localparam int DEPTH = 4;
   logic clk = 1'b0, reset = 1'b1;
   logic mem_valid = 1'b0, alu_valid = 1'b0;
   logic [4:0] mem_rd = '0, alu_rd = '0, query_a = '0, query_b = '0;
   logic [31:0] mem_data = '0, alu_data = '0;
   logic mem_ready, alu_ready, hazard_a, hazard_b, rf_write;
   logic [4:0] rf_addr_d;
   logic [31:0] rf_data;
   logic [$clog2(DEPTH):0] count;
   int n_checks = 0, n_errors = 0;
   typedef struct {logic [4:0] rd; logic [31:0] data;} wr_t;
   wr_t q[$];
   bit m_write = 0;
   logic [4:0] m_addr = '0;
   logic [31:0] m_data = '0;
   logic [31:0] bank [32];
   wb_queue #(.DEPTH(DEPTH), .DROP_R0(1'b1)) dut (
      .clk(clk), .reset(reset),
      .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .query_a(query_a), .query_b(query_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
      .rf_addr_d(rf_addr_d), .rf_data(rf_data), .rf_write(rf_write), .count(count)
   );
   always #5 clk = ~clk;
   always @(posedge clk) if (rf_write) bank[rf_addr_d] <= rf_data;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end
   endtask
   function automatic bit pend(input logic [4:0] r, input bit mhs, input logic [4:0] mrd,
                               input bit ahs, input logic [4:0] ard);
      if (r == 5'd0) return 0;
      foreach (q[i]) if (q[i].rd == r) return 1;
      return (m_write && m_addr == r) || (mhs && mrd == r) || (ahs && ard == r);
   endfunction
   // called just after a falling edge; returns just after the next falling edge
   task automatic step(input bit mv, input logic [4:0] mrd, input logic [31:0] md,
                       input bit av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic [4:0] qa, input logic [4:0] qb);
      bit pop, emr, ear, mhs, ahs;
      int free;
      mem_valid = mv; mem_rd = mrd; mem_data = md;
      alu_valid = av; alu_rd = ard; alu_data = ad;
      query_a = qa; query_b = qb;
      #1;
      pop  = q.size() > 0;
      free = DEPTH - q.size() + (pop ? 1 : 0);
      emr  = free >= 1;
      mhs  = mv && emr;
      ear  = free >= 1 + ((mhs && mrd != 0) ? 1 : 0);
      ahs  = av && ear;
      chk("mem_ready", 32'(mem_ready), 32'(emr));
      chk("alu_ready", 32'(alu_ready), 32'(ear));
      chk("hazard_a", 32'(hazard_a), 32'(pend(qa, mhs, mrd, ahs, ard)));
      chk("hazard_b", 32'(hazard_b), 32'(pend(qb, mhs, mrd, ahs, ard)));
      @(posedge clk);
      #1;
      m_write = pop;
      if (pop) begin
         m_addr = q[0].rd;
         m_data = q[0].data;
         void'(q.pop_front());
      end
      if (mhs && mrd != 0) q.push_back('{mrd, md});
      if (ahs && ard != 0) q.push_back('{ard, ad});
      chk("rf_write", 32'(rf_write), 32'(m_write));
      chk("rf_addr_d", 32'(rf_addr_d), 32'(m_addr));
      chk("rf_data", rf_data, m_data);
      chk("count", 32'(count), 32'(q.size()));
      @(negedge clk);
   endtask
   task automatic idle(input int n, input logic [4:0] qa);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, qa, 0);
   endtask
   initial begin
      foreach (bank[i]) bank[i] = '0;
      query_a = 5'd5;
      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      chk("reset_rf_write", 32'(rf_write), 0);
      chk("reset_count", 32'(count), 0);
      chk("reset_addr", 32'(rf_addr_d), 0);
      chk("reset_data", rf_data, 0);
      chk("reset_hazard", 32'(hazard_a), 0);
      reset = 1'b0;
      @(negedge clk);
      step(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
      step(0, 0, 0, 0, 0, 0, 5, 0);
      chk("single_write", 32'(rf_write), 1);
      chk("single_addr", 32'(rf_addr_d), 5);
      chk("single_data", rf_data, 32'hDEADBEEF);
      idle(2, 5);
      chk("single_held", rf_data, 32'hDEADBEEF);
      step(1, 7, 32'h11, 1, 7, 32'h22, 7, 0);
      idle(4, 7);
      chk("bank_r7", bank[7], 32'h22);
      for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 5'(i), 32'(i * 3), 1, 4);
      for (int i = 0; i < 5; i++) step(1, 5'(8 + i), 32'(100 + i), 1, 5'(16 + i), 32'(200 + i), 9, 18);
      chk("full_count", 32'(count), DEPTH);
      idle(6, 0);
      step(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0);
      chk("r0_count", 32'(count), 0);
      idle(3, 0);
      step(1, 3, 32'hA1, 1, 4, 32'hA2, 3, 4);
      step(1, 6, 32'hA3, 1, 9, 32'hA4, 6, 9);
      alu_valid = 0;
      mem_valid = 0;
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_write", 32'(rf_write), 0);
      chk("rst_mid_count", 32'(count), 0);
      chk("rst_mid_hazard", 32'(hazard_a), 0);
      chk("rst_mid_hazard_b", 32'(hazard_b), 0);
      #1 reset = 1'b0;
      q.delete();
      m_write = 0; m_addr = '0; m_data = '0;
      @(negedge clk);
      idle(4, 9);
      for (int i = 1; i <= 10; i++) step(1, 5'(i), 32'h1000 + 32'(i), 0, 0, 0, 5'(i), 0);
      idle(3, 0);
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      idle(8, 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
